// File: rtl/mod_n_count_monitor.sv
// -----------------------------------------------------------------------------
// mod_n_count_monitor
//
// Reader side of a mod-N up/down counter. Samples a count stream in the range
// 0..N-1 and decodes, per valid sample, whether the counter held, stepped up,
// or stepped down. Also decodes wrap events (N-1 -> 0 and 0 -> N-1) and keeps
// a signed revolution count. Jumps larger than one step and out-of-range
// values are flagged with a sticky error. By default the monitor then locks
// in FAULT until err_clr.
//
// Optional feature (macro MOD_N_MON_AUTORESYNC_EN):
//   When defined, an in-range but illegal jump while tracking raises err,
//   adopts the new sample as the reference, and keeps tracking. Out-of-range
//   samples still lock FAULT.
//
// Parameters:
//   N  modulus of the observed counter (N >= 2)
//   b  width of count_in (2**b >= N)
//   W  width of the signed turns accumulator
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   count_in  observed counter value
//   valid     count_in is sampled this cycle
//   err_clr   clears fault state and sticky error (loses to rst)
//   step      one-cycle pulse, legal +/-1 transition
//   hold      one-cycle pulse, sample equal to previous
//   dir       direction of last step (1 = up), held between steps
//   wrap_up   one-cycle pulse on N-1 -> 0
//   wrap_dn   one-cycle pulse on 0 -> N-1
//   turns     signed revolution count, wraps modulo 2**W
//   err       sticky error flag
//   state     00 = IDLE, 01 = TRACK, 10 = FAULT
// -----------------------------------------------------------------------------
module mod_n_count_monitor #(
    parameter int N = 16,
    parameter int b = 4,
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [b-1:0]        count_in,
    input  logic                valid,
    input  logic                err_clr,
    output logic                step,
    output logic                hold,
    output logic                dir,
    output logic                wrap_up,
    output logic                wrap_dn,
    output logic signed [W-1:0] turns,
    output logic                err,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        FAULT = 2'b10
    } state_t;

    localparam int            LP_MAX_INT = N - 1;
    localparam int            LP_ONE_INT = 1;
    localparam logic [b-1:0]  LP_MAX     = LP_MAX_INT[b-1:0];
    localparam logic [b-1:0]  LP_ONE_B   = LP_ONE_INT[b-1:0];
    localparam logic [W-1:0]  LP_ONE_W   = LP_ONE_INT[W-1:0];

    state_t                r_state;
    logic [b-1:0]          r_prev;
    logic                  r_step;
    logic                  r_hold;
    logic                  r_dir;
    logic                  r_wrapUp;
    logic                  r_wrapDn;
    logic signed [W-1:0]   r_turns;
    logic                  r_err;

    state_t                w_stateNext;
    logic [b-1:0]          w_prevNext;
    logic                  w_stepNext;
    logic                  w_holdNext;
    logic                  w_dirNext;
    logic                  w_wrapUpNext;
    logic                  w_wrapDnNext;
    logic signed [W-1:0]   w_turnsNext;
    logic                  w_errNext;

    logic                  w_inRange;
    logic                  w_prevAtMax;
    logic                  w_prevAtZero;
    logic [b-1:0]          w_prevUp;
    logic [b-1:0]          w_prevDn;
    logic                  w_isHold;
    logic                  w_isUp;
    logic                  w_isDn;

    // When the input width exactly covers the modulus every code is legal,
    // so the range compare is skipped instead of being a constant compare.
    generate
        if ((2 ** b) > N) begin : g_rangeCheck
            assign w_inRange = (count_in <= LP_MAX);
        end else begin : g_fullRange
            assign w_inRange = 1'b1;
        end
    endgenerate

    // Modular neighbours of the reference sample. For N = 2 both are the
    // same value; the up decode is tested first so it wins.
    assign w_prevAtMax  = (r_prev == LP_MAX);
    assign w_prevAtZero = (r_prev == '0);
    assign w_prevUp     = w_prevAtMax  ? '0     : (r_prev + LP_ONE_B);
    assign w_prevDn     = w_prevAtZero ? LP_MAX : (r_prev - LP_ONE_B);
    assign w_isHold     = (count_in == r_prev);
    assign w_isUp       = (count_in == w_prevUp);
    assign w_isDn       = (count_in == w_prevDn);

    // State register plus all registered outputs; rst dominates err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_prev   <= '0;
            r_step   <= 1'b0;
            r_hold   <= 1'b0;
            r_dir    <= 1'b1;
            r_wrapUp <= 1'b0;
            r_wrapDn <= 1'b0;
            r_turns  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_prev   <= w_prevNext;
            r_step   <= w_stepNext;
            r_hold   <= w_holdNext;
            r_dir    <= w_dirNext;
            r_wrapUp <= w_wrapUpNext;
            r_wrapDn <= w_wrapDnNext;
            r_turns  <= w_turnsNext;
            r_err    <= w_errNext;
        end
    end

    // Next-state decode. err_clr always returns to IDLE and discards any
    // sample in the same cycle; FAULT ignores samples entirely.
    always_comb begin
        w_stateNext = r_state;
        if (err_clr) begin
            w_stateNext = IDLE;
        end else if (valid) begin
            case (r_state)
                IDLE: begin
                    w_stateNext = w_inRange ? TRACK : FAULT;
                end
                TRACK: begin
                    if (!w_inRange) begin
                        w_stateNext = FAULT;
                    end else if (!(w_isHold || w_isUp || w_isDn)) begin
`ifdef MOD_N_MON_AUTORESYNC_EN
                        w_stateNext = TRACK;
`else
                        w_stateNext = FAULT;
`endif
                    end
                end
                FAULT: begin
                    w_stateNext = FAULT;
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    // Next values of the registered outputs and the reference sample.
    // Pulses default low so they last exactly one cycle.
    always_comb begin
        w_prevNext   = r_prev;
        w_stepNext   = 1'b0;
        w_holdNext   = 1'b0;
        w_dirNext    = r_dir;
        w_wrapUpNext = 1'b0;
        w_wrapDnNext = 1'b0;
        w_turnsNext  = r_turns;
        w_errNext    = r_err;
        if (err_clr) begin
            w_errNext = 1'b0;
        end else if (valid) begin
            case (r_state)
                IDLE: begin
                    if (w_inRange) begin
                        w_prevNext = count_in;
                    end else begin
                        w_errNext = 1'b1;
                    end
                end
                TRACK: begin
                    if (!w_inRange) begin
                        w_errNext = 1'b1;
                    end else if (w_isHold) begin
                        w_holdNext = 1'b1;
                        w_prevNext = count_in;
                    end else if (w_isUp) begin
                        w_stepNext = 1'b1;
                        w_dirNext  = 1'b1;
                        w_prevNext = count_in;
                        if (w_prevAtMax) begin
                            w_wrapUpNext = 1'b1;
                            w_turnsNext  = r_turns + LP_ONE_W;
                        end
                    end else if (w_isDn) begin
                        w_stepNext = 1'b1;
                        w_dirNext  = 1'b0;
                        w_prevNext = count_in;
                        if (w_prevAtZero) begin
                            w_wrapDnNext = 1'b1;
                            w_turnsNext  = r_turns - LP_ONE_W;
                        end
                    end else begin
                        w_errNext = 1'b1;
`ifdef MOD_N_MON_AUTORESYNC_EN
                        w_prevNext = count_in;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign step    = r_step;
    assign hold    = r_hold;
    assign dir     = r_dir;
    assign wrap_up = r_wrapUp;
    assign wrap_dn = r_wrapDn;
    assign turns   = r_turns;
    assign err     = r_err;
    assign state   = r_state;

endmodule

// File: tb/tb_mod_n_count_monitor.sv
// -----------------------------------------------------------------------------
// tb_mod_n_count_monitor
//
// Two monitors share clock and control: dut0 (N=16, b=4) and dut1 (N=16, b=5,
// so out-of-range codes 16..31 can be presented). A behavioural model built on
// modular differences predicts every output of both monitors after each edge.
// -----------------------------------------------------------------------------
module tb_mod_n_count_monitor;

    localparam int N = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid;
    logic              errClr;
    logic [3:0]        countIn0;
    logic [4:0]        countIn1;

    logic              step0, hold0, dir0, wrapUp0, wrapDn0, err0;
    logic signed [7:0] turns0;
    logic [1:0]        state0;
    logic              step1, hold1, dir1, wrapUp1, wrapDn1, err1;
    logic signed [7:0] turns1;
    logic [1:0]        state1;

    logic [15:0]       obsVec [2];

    // Expected-state model, one entry per monitor
    int                eState [2];
    int                ePrev  [2];
    int                eTurns [2];
    logic              eStep  [2];
    logic              eHold  [2];
    logic              eDir   [2];
    logic              eWu    [2];
    logic              eWd    [2];
    logic              eErr   [2];

    int                checks   = 0;
    int                failures = 0;

    always #5 clk = ~clk;

    mod_n_count_monitor #(.N(16), .b(4), .W(8)) dut0 (
        .clk(clk), .rst(rst), .count_in(countIn0), .valid(valid),
        .err_clr(errClr), .step(step0), .hold(hold0), .dir(dir0),
        .wrap_up(wrapUp0), .wrap_dn(wrapDn0), .turns(turns0), .err(err0),
        .state(state0)
    );

    mod_n_count_monitor #(.N(16), .b(5), .W(8)) dut1 (
        .clk(clk), .rst(rst), .count_in(countIn1), .valid(valid),
        .err_clr(errClr), .step(step1), .hold(hold1), .dir(dir1),
        .wrap_up(wrapUp1), .wrap_dn(wrapDn1), .turns(turns1), .err(err1),
        .state(state1)
    );

    always_comb begin
        obsVec[0] = {step0, hold0, dir0, wrapUp0, wrapDn0, turns0, err0, state0};
        obsVec[1] = {step1, hold1, dir1, wrapUp1, wrapDn1, turns1, err1, state1};
    end

    function automatic logic [15:0] expVec(int k);
        logic [7:0] t;
        logic [1:0] s;
        t = eTurns[k][7:0];
        s = eState[k][1:0];
        return {eStep[k], eHold[k], eDir[k], eWu[k], eWd[k], t, eErr[k], s};
    endfunction

    // Model: state 0 = IDLE, 1 = TRACK, 2 = FAULT. Legality is judged by the
    // modular distance between the new sample and the reference.
    task automatic modelStep(int k, bit r, bit v, int c, bit clr);
        int d;
        eStep[k] = 1'b0; eHold[k] = 1'b0; eWu[k] = 1'b0; eWd[k] = 1'b0;
        if (r) begin
            eState[k] = 0; ePrev[k] = 0; eDir[k] = 1'b1; eTurns[k] = 0; eErr[k] = 1'b0;
        end else if (clr) begin
            eErr[k] = 1'b0; eState[k] = 0;
        end else if (v) begin
            if (eState[k] == 0) begin
                if (c < N) begin ePrev[k] = c; eState[k] = 1; end
                else begin eErr[k] = 1'b1; eState[k] = 2; end
            end else if (eState[k] == 1) begin
                if (c >= N) begin
                    eErr[k] = 1'b1; eState[k] = 2;
                end else begin
                    d = (c - ePrev[k] + N) % N;
                    if (d == 0) begin
                        eHold[k] = 1'b1; ePrev[k] = c;
                    end else if (d == 1) begin
                        eStep[k] = 1'b1; eDir[k] = 1'b1;
                        if (c == 0) begin eWu[k] = 1'b1; eTurns[k] = eTurns[k] + 1; end
                        ePrev[k] = c;
                    end else if (d == N - 1) begin
                        eStep[k] = 1'b1; eDir[k] = 1'b0;
                        if (c == N - 1) begin eWd[k] = 1'b1; eTurns[k] = eTurns[k] - 1; end
                        ePrev[k] = c;
                    end else begin
                        eErr[k] = 1'b1;
`ifdef MOD_N_MON_AUTORESYNC_EN
                        ePrev[k] = c;
`else
                        eState[k] = 2;
`endif
                    end
                end
            end
        end
    endtask

    // One clock of stimulus; dut0 sees the value modulo 16
    task automatic applyStimulus(bit r, bit v, int c, bit clr);
        logic [4:0] cv;
        cv       = c[4:0];
        rst      = r;
        valid    = v;
        errClr   = clr;
        countIn0 = cv[3:0];
        countIn1 = cv;
        modelStep(0, r, v, c % 16, clr);
        modelStep(1, r, v, c, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 7, 1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obsVec[k] !== 16'h2000) begin
                failures++;
                $display("[TB] FAIL reset dut%0d: got %h, expected %h", k, obsVec[k], 16'h2000);
            end
        end
        applyStimulus(0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obsVec[k] !== expVec(k)) begin
                failures++;
                $display("[TB] FAIL reset_idle dut%0d: got %h, expected %h", k, obsVec[k], expVec(k));
            end
        end
    endtask

    task automatic test_wrap_up();
        int s[4] = '{14, 15, 0, 1};
        foreach (s[i]) begin
            applyStimulus(0, 1, s[i], 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obsVec[k] !== expVec(k)) begin
                    failures++;
                    $display("[TB] FAIL wrap_up dut%0d sample %0d: got %h, expected %h", k, s[i], obsVec[k], expVec(k));
                end
            end
        end
        checks++;
        if (turns0 !== 8'sd1) begin
            failures++;
            $display("[TB] FAIL wrap_up_turns: got %0d, expected 1", turns0);
        end
    endtask

    task automatic test_wrap_down();
        int s[4] = '{1, 0, 15, 15};
        foreach (s[i]) begin
            applyStimulus(0, 1, s[i], 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obsVec[k] !== expVec(k)) begin
                    failures++;
                    $display("[TB] FAIL wrap_down dut%0d sample %0d: got %h, expected %h", k, s[i], obsVec[k], expVec(k));
                end
            end
        end
        checks++;
        if (turns0 !== 8'sd0 || hold0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wrap_down_final: got turns %0d hold %b, expected turns 0 hold 1", turns0, hold0);
        end
    endtask

    task automatic test_fault();
        // clear, re-acquire at 5, jump to 7, ignored samples, clear, re-acquire at 9
        int s[8]   = '{0, 5, 7, 8, 9, 0, 0, 9};
        bit v[8]   = '{0, 1, 1, 1, 1, 0, 0, 1};
        bit clr[8] = '{1, 0, 0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, v[i], s[i], clr[i]);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obsVec[k] !== expVec(k)) begin
                    failures++;
                    $display("[TB] FAIL fault dut%0d step %0d: got %h, expected %h", k, i, obsVec[k], expVec(k));
                end
            end
`ifndef MOD_N_MON_AUTORESYNC_EN
            if (i == 2) begin
                checks++;
                if (state0 !== 2'b10 || err0 !== 1'b1 || step0 !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL fault_entry: got state %b err %b step %b, expected 10 1 0", state0, err0, step0);
                end
            end
`endif
        end
    endtask

    task automatic test_turns_wrap();
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        for (int rev = 0; rev < 128; rev++) begin
            for (int j = 1; j <= 16; j++) begin
                applyStimulus(0, 1, j % 16, 0);
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (obsVec[k] !== expVec(k)) begin
                        failures++;
                        $display("[TB] FAIL turns_wrap dut%0d rev %0d: got %h, expected %h", k, rev, obsVec[k], expVec(k));
                    end
                end
            end
        end
        checks++;
        if (turns0 !== 8'sh80) begin
            failures++;
            $display("[TB] FAIL turns_wrap_final: got %h, expected 80", turns0);
        end
    endtask

    task automatic test_clr_and_reset();
        applyStimulus(0, 1, 1, 1);
        checks++;
        if (state0 !== 2'b00 || step0 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clr_with_valid: got state %b step %b, expected 00 0", state0, step0);
        end
        applyStimulus(0, 1, 10, 0);
        applyStimulus(0, 1, 11, 0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obsVec[k] !== expVec(k)) begin
                failures++;
                $display("[TB] FAIL clr_then_track dut%0d: got %h, expected %h", k, obsVec[k], expVec(k));
            end
        end
        applyStimulus(1, 1, 12, 1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obsVec[k] !== 16'h2000) begin
                failures++;
                $display("[TB] FAIL reset_mid_stream dut%0d: got %h, expected %h", k, obsVec[k], 16'h2000);
            end
        end
    endtask

    task automatic test_out_of_range();
        int s[5]   = '{20, 0, 3, 20, 4};
        bit clr[5] = '{0, 1, 0, 0, 0};
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, !clr[i], s[i], clr[i]);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obsVec[k] !== expVec(k)) begin
                    failures++;
                    $display("[TB] FAIL out_of_range dut%0d step %0d: got %h, expected %h", k, i, obsVec[k], expVec(k));
                end
            end
        end
        checks++;
        if (state1 !== 2'b10 || err1 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL out_of_range_fault: got state %b err %b, expected 10 1", state1, err1);
        end
    endtask

`ifdef MOD_N_MON_AUTORESYNC_EN
    task automatic test_autoresync();
        int s[3] = '{9, 10, 20};
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 1, 3, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, s[i], 0);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obsVec[k] !== expVec(k)) begin
                    failures++;
                    $display("[TB] FAIL autoresync dut%0d sample %0d: got %h, expected %h", k, s[i], obsVec[k], expVec(k));
                end
            end
            if (i == 0) begin
                checks++;
                if (state0 !== 2'b01 || err0 !== 1'b1 || step0 !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL autoresync_stay: got state %b err %b step %b, expected 01 1 0", state0, err0, step0);
                end
            end
        end
        checks++;
        if (state1 !== 2'b10) begin
            failures++;
            $display("[TB] FAIL autoresync_range: got state %b, expected 10", state1);
        end
    endtask
`endif

    task automatic test_random();
        int last = 0;
        int c;
        int pick;
        bit r, v, clr;
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            r    = ($urandom_range(0, 99) == 0);
            clr  = ($urandom_range(0, 29) == 0);
            v    = ($urandom_range(0, 3) != 0);
            pick = $urandom_range(0, 9);
            if (pick < 4)      c = (last + 1) % 16;
            else if (pick < 7) c = (last + 15) % 16;
            else if (pick < 8) c = last;
            else if (pick < 9) c = $urandom_range(0, 15);
            else               c = $urandom_range(0, 31);
            if (c < 16) last = c;
            applyStimulus(r, v, c, clr);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obsVec[k] !== expVec(k)) begin
                    failures++;
                    $display("[TB] FAIL random dut%0d cycle %0d: got %h, expected %h", k, i, obsVec[k], expVec(k));
                end
            end
        end
    endtask

    // Scenarios run back to back; each relies on where the previous one left off
    initial begin
        rst      = 1'b1;
        valid    = 1'b0;
        errClr   = 1'b0;
        countIn0 = '0;
        countIn1 = '0;
        #1;
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_fault();
        test_turns_wrap();
        test_clr_and_reset();
        test_out_of_range();
`ifdef MOD_N_MON_AUTORESYNC_EN
        test_autoresync();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod_n_count_monitor.md
Name: mod_n_count_monitor

Overview:
- Reader side of the mod-N up/down counter.
- Samples a count stream (0..N-1) produced by a counter such as our mod-N up/down counter, or received from a remote one.
- Decodes per-sample direction, step/hold, and wrap events; keeps a signed revolution (turns) count.
- Flags illegal transitions: jumps of more than one step, or values out of range.
- Used for position tracking and counter integrity checking.

Parameters:
- N, 16, modulus of the observed counter; legal values are 0..N-1; N >= 2.
- b, 4, width of the count input; 2^b >= N.
- W, 8, width of the signed turns accumulator.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- count_in  input  b  observed counter value
- valid  input  1  count_in is sampled this cycle
- err_clr  input  1  clears fault state and sticky error
- step  output  1  one-cycle pulse: legal ±1 transition decoded
- hold  output  1  one-cycle pulse: sample equal to previous
- dir  output  1  direction of last step: 1 = up, 0 = down; holds value between steps
- wrap_up  output  1  one-cycle pulse: N-1 -> 0 transition
- wrap_dn  output  1  one-cycle pulse: 0 -> N-1 transition
- turns  output  W  signed revolution count, two's complement
- err  output  1  sticky error flag
- state  output  2  00 = IDLE, 01 = TRACK, 10 = FAULT

Behaviour:
- Reset is synchronous, active-high on rst, and applies at the clock edge.
  - On reset: state = IDLE, internal prev = 0, step = hold = wrap_up = wrap_dn = 0, dir = 1, turns = 0, err = 0.
  - Reset mid-operation discards the reference sample; the next valid sample re-acquires.
- All outputs are registered. Pulses assert in the cycle after the valid sample edge (latency 1) and last exactly one cycle.
- No valid input: all pulses are 0; dir, turns, err and state hold.
- IDLE:
  - valid with count_in < N -> prev = count_in, go to TRACK, no pulses.
  - valid with count_in >= N -> err = 1, go to FAULT.
- TRACK, on valid, checks in priority order:
  1. count_in >= N -> err = 1, go to FAULT, prev unchanged.
  2. count_in == prev -> hold pulse.
  3. count_in == (prev+1) mod N -> step, dir = 1. If prev == N-1, also wrap_up and turns = turns + 1.
  4. count_in == (prev-1) mod N -> step, dir = 0. If prev == 0, also wrap_dn and turns = turns - 1.
  5. Otherwise -> err = 1, go to FAULT, no step pulse.
  - On any legal sample (cases 2-4), prev = count_in.
- N = 2: +1 and -1 are the same value, so the up decode (case 3) wins.
- turns wraps modulo 2^W with no saturation: +127 + 1 -> -128 for W = 8.
- FAULT: samples are ignored; err stays 1; only err_clr exits.
- err_clr, in any state: err = 0, go to IDLE.
  - err_clr together with valid: err_clr wins and the sample is discarded.
  - turns and dir are preserved across err_clr.
- err_clr together with rst: reset wins.

Optional Feature:
- Macro: MOD_N_MON_AUTORESYNC_EN.
- Defined: an illegal sample in TRACK (case 5 only) sets err = 1, captures prev = count_in, and stays in TRACK.
  - No step and no wrap pulses for that sample.
  - Out-of-range samples (case 1) still go to FAULT.
- Undefined: behaviour exactly as above; any illegal sample locks FAULT until err_clr.

Test Plan:
- N = 16, W = 8. Reset, then valid samples 14, 15, 0, 1 -> state TRACK after 14; step pulses for 15, 0 and 1 with dir = 1; wrap_up only on the 0 sample; turns = 1.
- After the previous scenario, samples 1, 0, 15, 15 -> steps with dir = 0 on 0 and 15; wrap_dn on 15; hold on the final 15; turns = 0.
- TRACK with prev = 5, sample 7 -> err = 1, state FAULT, no step. Samples 8, 9 are then ignored. err_clr -> IDLE, err = 0. Sample 9 re-acquires with no pulses.
- 128 consecutive up revolutions from 0 -> turns = -128 (0x80), i.e. wraps from +127.
- Same cycle as a valid sample, assert err_clr -> sample discarded, state IDLE. rst asserted in TRACK mid-stream -> next cycle all outputs at reset values, turns = 0.
- With MOD_N_MON_AUTORESYNC_EN defined: prev = 3, sample 9 -> err = 1, state stays TRACK. Next sample 10 -> step, dir = 1. Sample 20 at b = 5, N = 16 -> FAULT.
